// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for the data-SRAM response of an issued load,
// extends the load data and offers {we,dest,result,pc} to write-back plus a forward bus to decode.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_allowin,
  output logic        ms_allowin,
  input  logic        es_to_ms_valid,
  input  logic [74:0] es_to_ms_bus,
  output logic        ms_to_ws_valid,
  output logic [69:0] ms_to_ws_bus,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic [38:0] stuck_ms_to_ds_bus
);

  localparam int ES_TO_MS_BUS_WD = 75;
  localparam int MS_TO_WS_BUS_WD = 70;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t                       state_r;
  state_t                       state_nxt_s;
  logic [ES_TO_MS_BUS_WD-1:0]   es_bus_s;
  logic [MS_TO_WS_BUS_WD-1:0]   ws_bus_s;
  logic [2:0]                   ld_op_r;
  logic                         mem_re_r;
  logic                         gr_we_r;
  logic [4:0]                   dest_r;
  logic [31:0]                  alu_r;
  logic [31:0]                  pc_r;
  logic [31:0]                  buf_r;
  logic                         buf_valid_r;
  logic                         ms_valid_s;
  logic                         pending_s;
  logic                         ready_go_s;
  logic                         capture_s;
  logic [31:0]                  word_s;
  logic [31:0]                  final_s;
  logic                         fwd_valid_s;
  logic                         fwd_blocked_s;
  logic                         unused_rsvd_s;

  assign es_bus_s      = es_to_ms_bus;
  assign unused_rsvd_s = es_bus_s[32];
  assign ms_to_ws_bus  = ws_bus_s;

  function automatic logic [31:0] load_ext(input logic [2:0]  op,
                                           input logic [31:0] word,
                                           input logic [1:0]  off);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (off)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    if (off[1]) begin
      half_v = word[31:16];
    end else begin
      half_v = word[15:0];
    end
    case (op)
      3'b001:  res_v = {{24{byte_v[7]}}, byte_v};
      3'b010:  res_v = {24'd0, byte_v};
      3'b011:  res_v = {{16{half_v[15]}}, half_v};
      3'b100:  res_v = {16'd0, half_v};
      default: res_v = word;
    endcase
    return res_v;
  endfunction

  // State register: EMPTY / WAIT (load outstanding) / READY
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a capture always overrides the drain transitions
  always_comb begin
    state_nxt_s = state_r;
    if (capture_s) begin
      if (es_bus_s[71]) begin
        state_nxt_s = ST_WAIT;
      end else begin
        state_nxt_s = ST_READY;
      end
    end else begin
      case (state_r)
        ST_EMPTY: state_nxt_s = ST_EMPTY;
        ST_WAIT: begin
          if (data_sram_data_ok) begin
            if (ws_allowin) begin
              state_nxt_s = ST_EMPTY;
            end else begin
              state_nxt_s = ST_READY;
            end
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_READY: begin
          if (ws_allowin) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_READY;
          end
        end
        default: state_nxt_s = ST_EMPTY;
      endcase
    end
  end

  // Instruction payload and the buffer holding load data that WB could not take yet
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_op_r     <= 3'd0;
      mem_re_r    <= 1'b0;
      gr_we_r     <= 1'b0;
      dest_r      <= 5'd0;
      alu_r       <= 32'd0;
      pc_r        <= 32'd0;
      buf_r       <= 32'd0;
      buf_valid_r <= 1'b0;
    end else if (capture_s) begin
      ld_op_r     <= es_bus_s[74:72];
      mem_re_r    <= es_bus_s[71];
      gr_we_r     <= es_bus_s[70];
      dest_r      <= es_bus_s[69:65];
      alu_r       <= es_bus_s[64:33];
      pc_r        <= es_bus_s[31:0];
      buf_valid_r <= 1'b0;
    end else if ((state_r == ST_WAIT) && data_sram_data_ok && !ws_allowin) begin
      buf_r       <= data_sram_rdata;
      buf_valid_r <= 1'b1;
    end
  end

  // Handshake, result selection and forward bus; rdata bypasses straight to WB while waiting
  always_comb begin
    ms_valid_s     = (state_r != ST_EMPTY);
    pending_s      = (state_r == ST_WAIT);
    ready_go_s     = !pending_s || data_sram_data_ok;
    ms_allowin     = !ms_valid_s || (ready_go_s && ws_allowin);
    capture_s      = es_to_ms_valid && ms_allowin;
    ms_to_ws_valid = ms_valid_s && ready_go_s;
    if (buf_valid_r) begin
      word_s = buf_r;
    end else begin
      word_s = data_sram_rdata;
    end
    if (mem_re_r) begin
      final_s = load_ext(ld_op_r, word_s, alu_r[1:0]);
    end else begin
      final_s = alu_r;
    end
    ws_bus_s      = {gr_we_r, dest_r, final_s, pc_r};
    fwd_valid_s   = ms_valid_s && gr_we_r && (dest_r != 5'd0);
    fwd_blocked_s = fwd_valid_s && pending_s && !data_sram_data_ok;
    if (fwd_valid_s) begin
      stuck_ms_to_ds_bus = {1'b1, fwd_blocked_s, dest_r, final_s};
    end else begin
      stuck_ms_to_ds_bus = 39'd0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single-instruction vectors plus
// hand-written sequences for stalls, buffering, reset mid-load and back-to-back issue.
module tb_mem_stage;

  logic        clk_s;
  logic        reset_s;
  logic        ws_allowin_s;
  logic        ms_allowin_s;
  logic        es_valid_s;
  logic [74:0] es_bus_s;
  logic        ms_to_ws_valid_s;
  logic [69:0] ms_to_ws_bus_s;
  logic        data_ok_s;
  logic [31:0] rdata_s;
  logic [38:0] stuck_s;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  ld_op;
    logic        mem_re;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[13];

  mem_stage dut (
    .clk                (clk_s),
    .reset              (reset_s),
    .ws_allowin         (ws_allowin_s),
    .ms_allowin         (ms_allowin_s),
    .es_to_ms_valid     (es_valid_s),
    .es_to_ms_bus       (es_bus_s),
    .ms_to_ws_valid     (ms_to_ws_valid_s),
    .ms_to_ws_bus       (ms_to_ws_bus_s),
    .data_sram_data_ok  (data_ok_s),
    .data_sram_rdata    (rdata_s),
    .stuck_ms_to_ds_bus (stuck_s)
  );

  initial clk_s = 1'b0;
  // Free-running 10-unit clock
  always #5 clk_s = ~clk_s;

  function automatic logic [74:0] mk_bus(input logic [2:0] op, input logic re, input logic we,
                                         input logic [4:0] dest, input logic [31:0] alu,
                                         input logic [31:0] pc);
    return {op, re, we, dest, alu, 1'b0, pc};
  endfunction

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic drive_capture(input logic [74:0] bus);
    @(negedge clk_s);
    es_valid_s   = 1'b1;
    es_bus_s     = bus;
    ws_allowin_s = 1'b1;
    data_ok_s    = 1'b0;
    rdata_s      = 32'd0;
  endtask

  initial begin
    logic [31:0] pc;
    logic [38:0] exp_stuck;

    reset_s      = 1'b1;
    ws_allowin_s = 1'b1;
    es_valid_s   = 1'b0;
    es_bus_s     = 75'd0;
    data_ok_s    = 1'b0;
    rdata_s      = 32'd0;

    vecs[0]  = '{3'b000, 1'b0, 1'b1, 5'd3,  32'h12345678, 32'h00000000, 32'h12345678};
    vecs[1]  = '{3'b001, 1'b1, 1'b1, 5'd4,  32'h00000103, 32'h80AABBCC, 32'hFFFFFF80};
    vecs[2]  = '{3'b010, 1'b1, 1'b1, 5'd4,  32'h00000103, 32'h80AABBCC, 32'h00000080};
    vecs[3]  = '{3'b100, 1'b1, 1'b1, 5'd4,  32'h00000102, 32'h80AABBCC, 32'h000080AA};
    vecs[4]  = '{3'b011, 1'b1, 1'b1, 5'd4,  32'h00000102, 32'h80AABBCC, 32'hFFFF80AA};
    vecs[5]  = '{3'b001, 1'b1, 1'b1, 5'd4,  32'h00000101, 32'h80AABBCC, 32'hFFFFFFBB};
    vecs[6]  = '{3'b010, 1'b1, 1'b1, 5'd4,  32'h00000100, 32'h80AABBCC, 32'h000000CC};
    vecs[7]  = '{3'b011, 1'b1, 1'b1, 5'd4,  32'h00000100, 32'h80AABBCC, 32'hFFFFBBCC};
    vecs[8]  = '{3'b000, 1'b1, 1'b1, 5'd10, 32'h00000200, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[9]  = '{3'b111, 1'b1, 1'b1, 5'd11, 32'h00000201, 32'h01020304, 32'h01020304};
    vecs[10] = '{3'b000, 1'b0, 1'b1, 5'd0,  32'h0000ABCD, 32'h00000000, 32'h0000ABCD};
    vecs[11] = '{3'b000, 1'b0, 1'b0, 5'd5,  32'h55AA55AA, 32'h00000000, 32'h55AA55AA};
    vecs[12] = '{3'b001, 1'b1, 1'b1, 5'd12, 32'h00000302, 32'h12345678, 32'h00000034};

    @(negedge clk_s);
    @(negedge clk_s);
    #1;
    check("rst_allowin", 70'(ms_allowin_s), 70'd1);
    check("rst_valid", 70'(ms_to_ws_valid_s), 70'd0);
    check("rst_stuck", 70'(stuck_s), 70'd0);
    @(negedge clk_s);
    reset_s = 1'b0;

    // Table: capture, answer loads immediately with WB ready, then expect empty
    for (int i = 0; i < 13; i++) begin
      pc = 32'h00001000 + 32'(i) * 32'd4;
      drive_capture(mk_bus(vecs[i].ld_op, vecs[i].mem_re, vecs[i].gr_we,
                           vecs[i].dest, vecs[i].alu, pc));
      #1;
      check("tbl_allowin", 70'(ms_allowin_s), 70'd1);
      @(negedge clk_s);
      es_valid_s = 1'b0;
      data_ok_s  = vecs[i].mem_re;
      rdata_s    = vecs[i].rdata;
      #1;
      if (vecs[i].gr_we && (vecs[i].dest != 5'd0)) begin
        exp_stuck = {1'b1, 1'b0, vecs[i].dest, vecs[i].res};
      end else begin
        exp_stuck = 39'd0;
      end
      check("tbl_valid", 70'(ms_to_ws_valid_s), 70'd1);
      check("tbl_bus", ms_to_ws_bus_s, {vecs[i].gr_we, vecs[i].dest, vecs[i].res, pc});
      check("tbl_stuck", 70'(stuck_s), 70'(exp_stuck));
      @(negedge clk_s);
      data_ok_s = 1'b0;
      #1;
      check("tbl_drained", 70'(ms_to_ws_valid_s), 70'd0);
    end

    // LW whose data arrives three cycles late
    drive_capture(mk_bus(3'b000, 1'b1, 1'b1, 5'd9, 32'h00000300, 32'h00002000));
    @(negedge clk_s);
    es_valid_s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("late_allowin", 70'(ms_allowin_s), 70'd0);
      check("late_valid", 70'(ms_to_ws_valid_s), 70'd0);
      check("late_blocked", 70'(stuck_s[38:37]), 70'd3);
      @(negedge clk_s);
    end
    data_ok_s = 1'b1;
    rdata_s   = 32'h11223344;
    #1;
    check("late_valid_ok", 70'(ms_to_ws_valid_s), 70'd1);
    check("late_bus", ms_to_ws_bus_s, {1'b1, 5'd9, 32'h11223344, 32'h00002000});
    check("late_stuck", 70'(stuck_s), 70'({1'b1, 1'b0, 5'd9, 32'h11223344}));
    @(negedge clk_s);
    data_ok_s = 1'b0;
    #1;
    check("late_drained", 70'(ms_to_ws_valid_s), 70'd0);

    // LW answered while WB stalls: data must be held, later rdata ignored
    drive_capture(mk_bus(3'b000, 1'b1, 1'b1, 5'd7, 32'h00000400, 32'h00003000));
    @(negedge clk_s);
    es_valid_s   = 1'b0;
    ws_allowin_s = 1'b0;
    data_ok_s    = 1'b1;
    rdata_s      = 32'hDEADBEEF;
    #1;
    check("buf_valid0", 70'(ms_to_ws_valid_s), 70'd1);
    check("buf_allowin0", 70'(ms_allowin_s), 70'd0);
    @(negedge clk_s);
    rdata_s = 32'h55555555;
    #1;
    check("buf_valid1", 70'(ms_to_ws_valid_s), 70'd1);
    check("buf_res1", 70'(ms_to_ws_bus_s[63:32]), 70'(32'hDEADBEEF));
    check("buf_stuck1", 70'(stuck_s), 70'({1'b1, 1'b0, 5'd7, 32'hDEADBEEF}));
    @(negedge clk_s);
    data_ok_s    = 1'b0;
    ws_allowin_s = 1'b1;
    #1;
    check("buf_bus2", ms_to_ws_bus_s, {1'b1, 5'd7, 32'hDEADBEEF, 32'h00003000});
    check("buf_allowin2", 70'(ms_allowin_s), 70'd1);
    @(negedge clk_s);
    data_ok_s = 1'b1;
    #1;
    check("stray_empty_valid", 70'(ms_to_ws_valid_s), 70'd0);
    check("stray_empty_allowin", 70'(ms_allowin_s), 70'd1);
    @(negedge clk_s);
    data_ok_s = 1'b0;
    #1;
    check("stray_empty_after", 70'(ms_to_ws_valid_s), 70'd0);

    // Reset pulse while a load is outstanding, then a stray data_ok
    drive_capture(mk_bus(3'b000, 1'b1, 1'b1, 5'd8, 32'h00000500, 32'h00004000));
    @(negedge clk_s);
    es_valid_s = 1'b0;
    #1;
    check("rstw_blocked", 70'(stuck_s[38:37]), 70'd3);
    @(negedge clk_s);
    reset_s = 1'b1;
    #1;
    check("rstw_allowin", 70'(ms_allowin_s), 70'd1);
    check("rstw_valid", 70'(ms_to_ws_valid_s), 70'd0);
    check("rstw_stuck", 70'(stuck_s), 70'd0);
    @(negedge clk_s);
    reset_s   = 1'b0;
    data_ok_s = 1'b1;
    rdata_s   = 32'h00000077;
    #1;
    check("rstw_stray_valid", 70'(ms_to_ws_valid_s), 70'd0);
    check("rstw_stray_allowin", 70'(ms_allowin_s), 70'd1);
    check("rstw_stray_stuck", 70'(stuck_s), 70'd0);
    @(negedge clk_s);
    data_ok_s = 1'b0;
    #1;
    check("rstw_after", 70'(ms_to_ws_valid_s), 70'd0);

    // Back-to-back LW then ADD with immediate data_ok: no bubble
    drive_capture(mk_bus(3'b000, 1'b1, 1'b1, 5'd5, 32'h00000600, 32'h00005000));
    @(negedge clk_s);
    es_bus_s  = mk_bus(3'b000, 1'b0, 1'b1, 5'd6, 32'hCAFEF00D, 32'h00005004);
    data_ok_s = 1'b1;
    rdata_s   = 32'hA5A5A5A5;
    #1;
    check("b2b_valid0", 70'(ms_to_ws_valid_s), 70'd1);
    check("b2b_bus0", ms_to_ws_bus_s, {1'b1, 5'd5, 32'hA5A5A5A5, 32'h00005000});
    check("b2b_allowin0", 70'(ms_allowin_s), 70'd1);
    @(negedge clk_s);
    es_valid_s = 1'b0;
    data_ok_s  = 1'b0;
    #1;
    check("b2b_valid1", 70'(ms_to_ws_valid_s), 70'd1);
    check("b2b_bus1", ms_to_ws_bus_s, {1'b1, 5'd6, 32'hCAFEF00D, 32'h00005004});
    @(negedge clk_s);
    #1;
    check("b2b_drained", 70'(ms_to_ws_valid_s), 70'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
